// File: rtl/cgra_cfg_pkg.sv
// Shared types and constants for the CGRA config streamer.
// The CRC helper is only used when CGRA_CFG_CRC_EN is defined.
package cgra_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    // Keeps address ports at least one bit wide when CHAIN_LEN is 1.
    function automatic int addr_w(input int len);
        return (len > 1) ? $clog2(len) : 1;
    endfunction

    function automatic logic [15:0] crc16_bit(
        input logic [15:0] c,
        input logic        b
    );
        logic fb;
        fb = c[15] ^ b;
        return {c[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/cgra_config_streamer_if.sv
// Host-side load/stream bundle for cgra_config_streamer.
// Carries crc_out only when CGRA_CFG_CRC_EN is defined.
interface cgra_config_streamer_if
    import cgra_cfg_pkg::*;
#(
    parameter int NUM_CHAINS = 2,
    parameter int CHAIN_LEN  = 285
);
    localparam int ADDR_W = addr_w(CHAIN_LEN);

    logic                  ld_valid;
    logic                  ld_ready;
    logic [ADDR_W-1:0]     ld_addr;
    logic [NUM_CHAINS-1:0] ld_data;
    logic                  start;
    logic                  enable;
    logic [NUM_CHAINS-1:0] bitstream;
    logic                  cfg_shift_en;
    logic                  busy;
    logic                  done;
`ifdef CGRA_CFG_CRC_EN
    logic [15:0]           crc_out;

    modport master (
        output ld_valid, ld_addr, ld_data, start, enable,
        input  ld_ready, bitstream, cfg_shift_en, busy, done,
        input  crc_out
    );
    modport slave (
        input  ld_valid, ld_addr, ld_data, start, enable,
        output ld_ready, bitstream, cfg_shift_en, busy, done,
        output crc_out
    );
`else
    modport master (
        output ld_valid, ld_addr, ld_data, start, enable,
        input  ld_ready, bitstream, cfg_shift_en, busy, done
    );
    modport slave (
        input  ld_valid, ld_addr, ld_data, start, enable,
        output ld_ready, bitstream, cfg_shift_en, busy, done
    );
`endif
endinterface

// File: rtl/cgra_cfg_column_store.sv
// Column store: one write port, one registered read port.
// The read register doubles as the bitstream output register.
module cgra_cfg_column_store #(
    parameter int NUM_CHAINS = 2,
    parameter int CHAIN_LEN  = 285,
    parameter int ADDR_W     = 9
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_W-1:0]     wr_addr_i,
    input  logic [NUM_CHAINS-1:0] wr_data_i,
    input  logic                  rd_en_i,
    input  logic                  rd_clr_i,
    input  logic [ADDR_W-1:0]     rd_addr_i,
    output logic [NUM_CHAINS-1:0] rd_data_o
);
    logic [NUM_CHAINS-1:0] mem_q [CHAIN_LEN];
    logic [NUM_CHAINS-1:0] rd_data_q;

    // No reset on the array: contents must survive a mid-stream abort.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_clr_i) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/cgra_config_streamer.sv
// Streams a host-loaded column image into NUM_CHAINS config scan chains.
// Define CGRA_CFG_CRC_EN to add a CRC-16-CCITT of the shifted image on crc_out.
module cgra_config_streamer
    import cgra_cfg_pkg::*;
#(
    parameter int NUM_CHAINS = 2,
    parameter int CHAIN_LEN  = 285
) (
    input  logic                   clock,
    input  logic                   sync_reset,
    cgra_config_streamer_if.slave  bus
);
    localparam int ADDR_W = addr_w(CHAIN_LEN);
    localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(CHAIN_LEN - 1);
    localparam logic [ADDR_W:0] LEN  = (ADDR_W+1)'(CHAIN_LEN);
    localparam logic [ADDR_W:0] ONE  = (ADDR_W+1)'(1);

    state_e          state_q;
    logic [ADDR_W:0] pos_q;
    logic            shift_en_q;
    logic            busy_q;
    logic            done_q;
    logic            we;
    logic            rd_en;
    logic            rd_clr;

    assign bus.ld_ready = (state_q != SHIFT);
    assign we     = bus.ld_valid && bus.ld_ready
                 && ({1'b0, bus.ld_addr} < LEN);
    assign rd_en  = (state_q == SHIFT) && bus.enable;
    assign rd_clr = sync_reset || (state_q != SHIFT);

    cgra_cfg_column_store #(
        .NUM_CHAINS (NUM_CHAINS),
        .CHAIN_LEN  (CHAIN_LEN),
        .ADDR_W     (ADDR_W)
    ) u_store (
        .clk       (clock),
        .we_i      (we),
        .wr_addr_i (bus.ld_addr),
        .wr_data_i (bus.ld_data),
        .rd_en_i   (rd_en),
        .rd_clr_i  (rd_clr),
        .rd_addr_i (pos_q[ADDR_W-1:0]),
        .rd_data_o (bus.bitstream)
    );

    always_ff @(posedge clock) begin
        if (sync_reset) begin
            state_q    <= IDLE;
            pos_q      <= '0;
            shift_en_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            shift_en_q <= 1'b0;
            unique case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state_q <= SHIFT;
                        pos_q   <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (bus.enable) begin
                        shift_en_q <= 1'b1;
                        pos_q      <= pos_q + ONE;
                        if (pos_q == LAST) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.cfg_shift_en = shift_en_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;

`ifdef CGRA_CFG_CRC_EN
    logic [15:0] crc_q;
    logic [15:0] crc_d;
    logic        crc_init;

    assign crc_init = sync_reset
                   || (bus.start && state_q != SHIFT);

    // Folds in the column on the chains this cycle, so the last column
    // is already included when done first rises.
    always_comb begin
        crc_d = crc_q;
        if (shift_en_q) begin
            for (int i = 0; i < NUM_CHAINS; i++) begin
                crc_d = crc16_bit(crc_d, bus.bitstream[i]);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (crc_init) begin
            crc_q <= CRC16_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign bus.crc_out = crc_d;
`endif

endmodule

// File: tb/tb_cgra_config_streamer.sv
// Scoreboard bench for cgra_config_streamer (NUM_CHAINS=2, CHAIN_LEN=8).
// Also checks crc_out when built with CGRA_CFG_CRC_EN.
module tb_cgra_config_streamer;
    localparam int NC = 2;
    localparam int CL = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cgra_config_streamer_if #(
        .NUM_CHAINS (NC),
        .CHAIN_LEN  (CL)
    ) bus ();

    cgra_config_streamer #(
        .NUM_CHAINS (NC),
        .CHAIN_LEN  (CL)
    ) dut (
        .clock      (clk),
        .sync_reset (rst),
        .bus        (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [NC-1:0] img [CL];
    logic [NC-1:0] sbq [$];

    task automatic chk(
        input string       name,
        input logic [31:0] act,
        input logic [31:0] req
    );
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h",
                     name, act, req);
        end
    endtask

    // Monitor: every cycle the chains shift, the next expected column
    // must be on the bitstream.
    initial begin
        logic [NC-1:0] exp_col;
        forever begin
            @(negedge clk);
            if (bus.cfg_shift_en !== 1'b0) begin
                if (sbq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_shift actual=%0h required=none",
                             bus.bitstream);
                end else begin
                    exp_col = sbq.pop_front();
                    chk("stream_col", 32'(bus.bitstream), 32'(exp_col));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [NC-1:0] d);
        bus.ld_valid = 1'b1;
        bus.ld_addr  = 3'(a);
        bus.ld_data  = d;
        chk("ld_ready_idle", 32'(bus.ld_ready), 1);
        step();
        bus.ld_valid = 1'b0;
        img[a] = d;
    endtask

    function automatic logic [15:0] model_crc();
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        for (int k = 0; k < CL; k++) begin
            for (int i = 0; i < NC; i++) begin
                fb = c[15] ^ img[k][i];
                c  = (c << 1) ^ (fb ? 16'h1021 : 16'h0000);
            end
        end
        return c;
    endfunction

    task automatic check_reset_outs();
        chk("rst_bitstream", 32'(bus.bitstream), 0);
        chk("rst_shift_en", 32'(bus.cfg_shift_en), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_ld_ready", 32'(bus.ld_ready), 1);
    endtask

    // One streaming run. rnd: random enable; [sa,sz]: stall cycles;
    // poke: blocked write + ignored start mid-run; abort_k: reset after
    // that many columns (-1 none); sw: write in the start cycle.
    task automatic run_stream(
        input bit            rnd,
        input int            sa,
        input int            sz,
        input bit            poke,
        input int            abort_k,
        input bit            sw,
        input int            sw_a,
        input logic [NC-1:0] sw_d
    );
        int   k;
        int   c;
        bit   en;
        logic [15:0] crc_exp;
        bus.start = 1'b1;
        if (sw) begin
            bus.ld_valid = 1'b1;
            bus.ld_addr  = 3'(sw_a);
            bus.ld_data  = sw_d;
            chk("ld_ready_start", 32'(bus.ld_ready), 1);
            img[sw_a] = sw_d;
        end
        step();
        bus.start    = 1'b0;
        bus.ld_valid = 1'b0;
        crc_exp = model_crc();
        k = 0;
        c = 0;
        while (k < CL && c < 64) begin
            chk("busy_shift", 32'(bus.busy), 1);
            if (abort_k == k) begin
                bus.enable = 1'b0;
                rst = 1'b1;
                step();
                rst = 1'b0;
                check_reset_outs();
                chk("abort_drained", 32'(sbq.size()), 0);
                return;
            end
            if (rnd) begin
                en = ($urandom_range(0, 3) != 0) || (c > 40);
            end else begin
                en = !(c >= sa && c <= sz);
            end
            bus.enable = en;
            if (poke && c == 2) begin
                bus.ld_valid = 1'b1;
                bus.ld_addr  = 3'd2;
                bus.ld_data  = ~img[2];
                bus.start    = 1'b1;
                chk("ld_ready_shift", 32'(bus.ld_ready), 0);
            end
            if (en) begin
                sbq.push_back(img[k]);
                k++;
            end
            step();
            bus.ld_valid = 1'b0;
            bus.start    = 1'b0;
            chk("shift_en", 32'(bus.cfg_shift_en), 32'(en));
            c++;
        end
        bus.enable = 1'b0;
        chk("done_rise", 32'(bus.done), 1);
        chk("busy_fall", 32'(bus.busy), 0);
        chk("run_cycles", 32'(c), 32'(CL + ((rnd || sz < sa) ? c - CL
                                            : sz - sa + 1)));
`ifdef CGRA_CFG_CRC_EN
        chk("crc_done", 32'(bus.crc_out), 32'(crc_exp));
`endif
        step();
        chk("done_sticky", 32'(bus.done), 1);
        chk("done_bitstream", 32'(bus.bitstream), 0);
        chk("done_shift_en", 32'(bus.cfg_shift_en), 0);
        chk("sb_drained", 32'(sbq.size()), 0);
`ifdef CGRA_CFG_CRC_EN
        chk("crc_stable", 32'(bus.crc_out), 32'(crc_exp));
`else
        if (crc_exp == 16'h0) chk("crc_model_nz", 32'(crc_exp), 1);
`endif
    endtask

    initial begin
        rst          = 1'b1;
        bus.ld_valid = 1'b0;
        bus.ld_addr  = '0;
        bus.ld_data  = '0;
        bus.start    = 1'b0;
        bus.enable   = 1'b0;
        step();
        step();
        check_reset_outs();
        rst = 1'b0;
        step();

        for (int a = 0; a < CL; a++) wr(a, 2'(a % 4));

        run_stream(0, 99, 0, 0, -1, 0, 0, '0);
        run_stream(0, 3, 4, 0, -1, 0, 0, '0);
        run_stream(0, 99, 0, 0, 4, 0, 0, '0);
        run_stream(0, 99, 0, 0, -1, 0, 0, '0);
        run_stream(0, 99, 0, 1, -1, 0, 0, '0);
        run_stream(0, 99, 0, 1, -1, 1, 7, 2'b11);

        for (int a = 0; a < CL; a++) wr(a, 2'b00);
        run_stream(0, 99, 0, 0, -1, 0, 0, '0);

        for (int r = 0; r < 6; r++) begin
            for (int a = 0; a < CL; a++) begin
                if ($urandom_range(0, 1) == 1) begin
                    wr(a, 2'($urandom));
                end
            end
            run_stream(1, 99, 0, r[0], -1, r[1],
                       int'($urandom_range(0, CL - 1)),
                       2'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
